// File: rtl/config_pkg.sv
// Shared configuration for the row-wise datapath:
// element/vector types, FU op codes and sequencer states.
package config_pkg;

   localparam int D = 4;
   localparam int FP_W = 16;
   localparam int DEF_NUM_VREGS = 8;

   typedef logic signed [FP_W-1:0] fixed_point_t;
   typedef fixed_point_t [D-1:0] vector_t;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_DIV = 3'd3,
      OP_EXP = 3'd4,
      OP_SIG = 3'd5
   } operation_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_ISSUE,
      S_RUN,
      S_WB
   } seq_state_e;

   function automatic logic op_legal(operation_t op);
      case (op)
         OP_ADD, OP_SUB, OP_MUL,
         OP_DIV, OP_EXP, OP_SIG: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rowwise_sequencer.sv
// Initiator of the row-wise FU handshake: reads two vectors,
// runs the FU element by element, writes the result back.
module rowwise_sequencer
   import config_pkg::*;
#(
   parameter int NUM_VREGS = DEF_NUM_VREGS,
   localparam int VREG_AW = $clog2(NUM_VREGS)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               instr_valid_i,
   output logic               instr_ready_o,
   input  operation_t         instr_op_i,
   input  logic [VREG_AW-1:0] instr_rs1_i,
   input  logic [VREG_AW-1:0] instr_rs2_i,
   input  logic [VREG_AW-1:0] instr_rd_i,
   output logic [VREG_AW-1:0] rf_raddr_a_o,
   output logic [VREG_AW-1:0] rf_raddr_b_o,
   input  vector_t            rf_rdata_a_i,
   input  vector_t            rf_rdata_b_i,
   output logic               rf_we_o,
   output logic [VREG_AW-1:0] rf_waddr_o,
   output vector_t            rf_wdata_o,
   output vector_t            fu_a_o,
   output vector_t            fu_b_o,
   output operation_t         fu_op_o,
   output logic               fu_valid_o,
   input  logic               fu_ready_i,
   input  vector_t            fu_new_result_i,
   output vector_t            fu_old_result_o,
   output logic               done_o,
   output logic               err_o
);

   seq_state_e         state_q, state_d;
   operation_t         op_q;
   logic [VREG_AW-1:0] rs1_q, rs2_q, rd_q;
   vector_t            a_q, b_q, result_q;
   logic               err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         op_q     <= OP_ADD;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            S_IDLE: begin
               if (instr_valid_i) begin
                  op_q  <= instr_op_i;
                  rs1_q <= instr_rs1_i;
                  rs2_q <= instr_rs2_i;
                  rd_q  <= instr_rd_i;
               end
            end
            S_READ: begin
               // sources captured here, so rd==rs1/rs2 is safe
               a_q   <= rf_rdata_a_i;
               b_q   <= rf_rdata_b_i;
               err_q <= !op_legal(op_q);
            end
            S_ISSUE: result_q <= '0;
            S_RUN: begin
               if (!fu_ready_i) result_q <= fu_new_result_i;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d       = state_q;
      instr_ready_o = 1'b0;
      rf_raddr_a_o  = rs1_q;
      rf_raddr_b_o  = rs2_q;
      fu_valid_o    = 1'b0;
      rf_we_o       = 1'b0;
      done_o        = 1'b0;
      err_o         = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            instr_ready_o = 1'b1;
            rf_raddr_a_o  = instr_rs1_i;
            rf_raddr_b_o  = instr_rs2_i;
            if (instr_valid_i) state_d = S_READ;
         end
         S_READ: begin
            state_d = op_legal(op_q) ? S_ISSUE : S_WB;
         end
         S_ISSUE: begin
            fu_valid_o = 1'b1;
            if (fu_ready_i) state_d = S_RUN;
         end
         S_RUN: begin
            // ready in the first RUN cycle is taken as done
            if (fu_ready_i) state_d = S_WB;
         end
         S_WB: begin
            rf_we_o = !err_q;
            done_o  = 1'b1;
            err_o   = err_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rf_waddr_o      = rd_q;
   assign rf_wdata_o      = result_q;
   assign fu_a_o          = a_q;
   assign fu_b_o          = b_q;
   assign fu_op_o         = op_q;
   assign fu_old_result_o = result_q;

endmodule

// File: tb/tb_rowwise_sequencer.sv
// Bench for rowwise_sequencer with a behavioural FU, a register
// file model and a scoreboard of expected retirements.
module tb_rowwise_sequencer;
   import config_pkg::*;

   localparam int NV = DEF_NUM_VREGS;
   localparam int AW = $clog2(NV);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          instr_valid;
   logic          instr_ready;
   operation_t    instr_op;
   logic [AW-1:0] instr_rs1, instr_rs2, instr_rd;
   logic [AW-1:0] raddr_a, raddr_b, waddr;
   vector_t       rdata_a, rdata_b, wdata;
   logic          rf_we;
   vector_t       fu_a, fu_b, fu_new, fu_old;
   operation_t    fu_op;
   logic          fu_valid, fu_ready;
   logic          done, err;

   always #5 clk = ~clk;

   rowwise_sequencer #(.NUM_VREGS(NV)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
      .instr_op_i(instr_op), .instr_rs1_i(instr_rs1),
      .instr_rs2_i(instr_rs2), .instr_rd_i(instr_rd),
      .rf_raddr_a_o(raddr_a), .rf_raddr_b_o(raddr_b),
      .rf_rdata_a_i(rdata_a), .rf_rdata_b_i(rdata_b),
      .rf_we_o(rf_we), .rf_waddr_o(waddr), .rf_wdata_o(wdata),
      .fu_a_o(fu_a), .fu_b_o(fu_b), .fu_op_o(fu_op),
      .fu_valid_o(fu_valid), .fu_ready_i(fu_ready),
      .fu_new_result_i(fu_new), .fu_old_result_o(fu_old),
      .done_o(done), .err_o(err)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int aborting = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string nm, logic [127:0] got, logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   function automatic fixed_point_t fn(operation_t op, fixed_point_t x, fixed_point_t y);
      case (op)
         OP_ADD:  return x + y;
         OP_SUB:  return x - y;
         OP_MUL:  return x * y;
         OP_DIV:  return (y == 0) ? fixed_point_t'(0) : x / y;
         OP_EXP:  return x <<< 1;
         OP_SIG:  return x >>> 1;
         default: return '0;
      endcase
   endfunction

   // register file: registered read, written on rf_we
   vector_t rf [NV];
   always @(posedge clk) begin
      rdata_a <= rf[raddr_a];
      rdata_b <= rf[raddr_b];
      if (rf_we) rf[waddr] <= wdata;
   end

   // FU: optional ISSUE stall, then one element per busy cycle
   int   fu_stall = 0;
   int   stall_ctr;
   int   fu_cnt;
   logic fu_busy;

   assign fu_ready = !fu_busy && (!fu_valid || stall_ctr >= fu_stall);

   always_comb begin
      fu_new = fu_old;
      fu_new[fu_cnt] = fn(fu_op, fu_a[fu_cnt], fu_b[fu_cnt]);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fu_busy   <= 1'b0;
         fu_cnt    <= 0;
         stall_ctr <= 0;
      end else if (fu_busy) begin
         if (fu_cnt == D - 1) begin
            fu_busy <= 1'b0;
            fu_cnt  <= 0;
         end else begin
            fu_cnt <= fu_cnt + 1;
         end
      end else if (fu_valid) begin
         if (fu_ready) begin
            fu_busy   <= 1'b1;
            fu_cnt    <= 0;
            stall_ctr <= 0;
         end else begin
            stall_ctr <= stall_ctr + 1;
         end
      end
   end

   a_first_run: assert property (@(posedge clk) disable iff (!rst_n)
      (fu_valid && fu_ready) |=> !fu_ready);

   // reference model
   typedef struct {
      operation_t    op;
      vector_t       a, b, res;
      logic          err;
      logic [AW-1:0] rd;
      int            due;
   } exp_t;

   exp_t    sb[$];
   vector_t mdl [NV];

   always @(negedge clk) begin
      if (rst_n) begin
         if (fu_valid && !aborting) begin
            if (sb.size() == 0) begin
               check("fu_valid_unexpected", 1, 0);
            end else begin
               check("fu_valid_on_err_op", sb[0].err, 0);
               check("fu_a", fu_a, sb[0].a);
               check("fu_b", fu_b, sb[0].b);
               check("fu_op", fu_op, sb[0].op);
            end
         end
         if (done) begin
            if (sb.size() == 0) begin
               check("done_unexpected", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("done_cycle", cyc, e.due);
               check("err", err, e.err);
               check("rf_we", rf_we, !e.err);
               if (!e.err) begin
                  check("waddr", waddr, e.rd);
                  check("wdata", wdata, e.res);
               end
            end
         end else if (rf_we || err) begin
            check("stray_we_or_err", {rf_we, err}, 2'b00);
         end
      end
   end

   task automatic poke(int idx, vector_t v);
      rf[idx]  = v;
      mdl[idx] = v;
   endtask

   task automatic issue(input operation_t op, input int rs1, input int rs2,
                        input int rd, input int stall, input bit hold,
                        input bit commit, output int acc);
      int   w;
      exp_t e;
      @(negedge clk);
      instr_op    = op;
      instr_rs1   = AW'(rs1);
      instr_rs2   = AW'(rs2);
      instr_rd    = AW'(rd);
      instr_valid = 1'b1;
      w = 0;
      while (!instr_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!instr_ready) check("accept_timeout", 0, 1);
      fu_stall = stall;
      acc = cyc;
      if (commit) begin
         e.op  = op;
         e.a   = mdl[rs1];
         e.b   = mdl[rs2];
         e.rd  = AW'(rd);
         e.err = (int'(op) > 5);
         for (int k = 0; k < D; k++)
            e.res[k] = fn(op, e.a[k], e.b[k]);
         e.due = acc + (e.err ? 2 : D + 4 + stall);
         sb.push_back(e);
         if (!e.err) mdl[rd] = e.res;
      end
      @(posedge clk);
      #1;
      if (!hold) instr_valid = 1'b0;
   endtask

   function automatic vector_t mk(int a, int b, int c, int d);
      vector_t v;
      v[0] = fixed_point_t'(a);
      v[1] = fixed_point_t'(b);
      v[2] = fixed_point_t'(c);
      v[3] = fixed_point_t'(d);
      return v;
   endfunction

   function automatic vector_t rnd_vec();
      vector_t v;
      for (int k = 0; k < D; k++)
         v[k] = fixed_point_t'(int'($urandom_range(0, 200)) - 100);
      return v;
   endfunction

   initial begin
      int a0, a1, w;
      operation_t rop;
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr_op    = OP_ADD;
      instr_rs1   = '0;
      instr_rs2   = '0;
      instr_rd    = '0;
      for (int i = 0; i < NV; i++) poke(i, rnd_vec());
      poke(1, mk(1, 2, 3, 4));
      poke(2, mk(10, 20, 30, 40));
      #12;
      check("rst_ready", instr_ready, 1);
      check("rst_fu_valid", fu_valid, 0);
      check("rst_we_done_err", {rf_we, done, err}, 3'b000);
      check("rst_result", fu_old, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD, nominal latency
      issue(OP_ADD, 1, 2, 3, 0, 0, 1, a0);
      // SUB with rd == rs1
      poke(1, mk(5, 5, 5, 5));
      poke(2, mk(1, 2, 3, 4));
      issue(OP_SUB, 1, 2, 1, 0, 0, 1, a0);
      // FU stalls 3 cycles in ISSUE
      issue(OP_MUL, 3, 2, 4, 3, 0, 1, a0);
      // unsupported encoding
      rop = operation_t'(3'd7);
      issue(rop, 2, 3, 5, 0, 0, 1, a0);

      // reset in the 2nd RUN cycle
      w = 0;
      while (sb.size() != 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      aborting = 1;
      issue(OP_ADD, 1, 2, 6, 0, 0, 0, a0);
      repeat (3) @(posedge clk);
      #2;
      check("run_before_rst", {instr_ready, fu_valid}, 2'b00);
      rst_n = 1'b0;
      #1;
      check("arst_ready", instr_ready, 1);
      check("arst_fu_valid", fu_valid, 0);
      check("arst_we_done_err", {rf_we, done, err}, 3'b000);
      check("arst_result", fu_old, 0);
      check("arst_fu_a", fu_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      aborting = 0;
      issue(OP_ADD, 1, 2, 6, 0, 0, 1, a0);

      // back-to-back with valid held
      issue(OP_ADD, 6, 1, 7, 0, 1, 1, a0);
      issue(OP_DIV, 7, 2, 0, 0, 0, 1, a1);
      check("b2b_spacing", a1 - a0, D + 5);

      // randomized
      for (int i = 0; i < 40; i++) begin
         rop = operation_t'(3'($urandom_range(0, 7)));
         issue(rop, $urandom_range(0, NV - 1), $urandom_range(0, NV - 1),
               $urandom_range(0, NV - 1), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1, a0);
      end
      instr_valid = 1'b0;

      w = 0;
      while (sb.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("scoreboard_drained", sb.size(), 0);
      for (int i = 0; i < NV; i++) check("final_rf", rf[i], mdl[i]);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rowwise_sequencer.md
Name: rowwise_sequencer

Overview:
Initiator side of the row-wise FU handshake. The block performs these steps for each instruction:
- Accepts one vector instruction (op, rs1, rs2, rd).
- Reads both source vectors from the vector register file.
- Issues them to the row-wise operation FU with valid/ready.
- Owns and feeds back the partial-result register while the FU works element by element.
- Writes the completed vector to rd.

It sits between the instruction decoder and the row-wise FU / vector register file.

Parameters:
NUM_VREGS, 8, number of vector registers; address width VREG_AW = $clog2(NUM_VREGS)
D, config_pkg::D, vector length (elements per vector_t); taken from the package, not overridden

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
instr_valid_i  in  1  instruction valid
instr_ready_o  out  1  sequencer can accept an instruction
instr_op_i  in  operation_t  row-wise operation
instr_rs1_i  in  VREG_AW  source A register
instr_rs2_i  in  VREG_AW  source B register (ignored for EXP/SIG)
instr_rd_i  in  VREG_AW  destination register
rf_raddr_a_o  out  VREG_AW  register-file read address A
rf_raddr_b_o  out  VREG_AW  register-file read address B
rf_rdata_a_i  in  vector_t  read data A, valid 1 cycle after address
rf_rdata_b_i  in  vector_t  read data B, valid 1 cycle after address
rf_we_o  out  1  register-file write enable
rf_waddr_o  out  VREG_AW  write address
rf_wdata_o  out  vector_t  write data
fu_a_o  out  vector_t  FU operand A, held stable from ISSUE until FU done
fu_b_o  out  vector_t  FU operand B, held stable
fu_op_o  out  operation_t  FU operation, held stable
fu_valid_o  out  1  FU input valid
fu_ready_i  in  1  FU input ready (low while FU is working)
fu_new_result_i  in  vector_t  FU combinational updated result
fu_old_result_o  out  vector_t  partial-result register fed back to FU
done_o  out  1  one-cycle pulse at instruction retirement
err_o  out  1  one-cycle pulse with done_o for an unsupported op

Behaviour:
- State machine: IDLE, READ, ISSUE, RUN, WRITEBACK.
- Reset values (async, while rst_ni=0): state IDLE; all registers '0; instr_ready_o=1; fu_valid_o=0; rf_we_o=0; done_o=0; err_o=0.
- Reset mid-operation aborts with no register-file write. The FU is assumed reset by the same rst_ni.

IDLE:
- instr_ready_o=1.
- rf_raddr_a/b_o driven combinationally from instr_rs1_i/instr_rs2_i.
- On instr_valid_i: latch op, rd, rs1, rs2 and go to READ.

READ:
- rf_raddr outputs come from the latched rs1/rs2.
- Capture rf_rdata_a/b_i into a_q/b_q.
- If the op is not in {ADD,SUB,MUL,DIV,EXP,SIG}: go to WRITEBACK with error flag set, no FU issue.
- Otherwise go to ISSUE.

ISSUE:
- fu_valid_o=1; result_q cleared to '0.
- Stay until fu_ready_i=1, then go to RUN.
- fu_valid_o must never be high outside ISSUE; otherwise the FU would restart after finishing.

RUN:
- Each cycle with fu_ready_i=0: result_q <= fu_new_result_i.
- First cycle with fu_ready_i=1: go to WRITEBACK.
- If fu_ready_i is still 1 in the first RUN cycle (protocol violation), treat it as done. The bench checks via assertion that this never happens with the real FU.

WRITEBACK:
- rf_we_o=1, rf_waddr_o=rd_q, rf_wdata_o=result_q, done_o=1, for exactly one cycle; then IDLE.
- Error case: rf_we_o=0, done_o=1, err_o=1.

Output holding rules:
- fu_a_o/fu_b_o/fu_op_o = a_q/b_q/op_q in every state; the registers change only in READ.
- fu_old_result_o = result_q.

Latency and throughput:
- With a ready FU: handshake at cycle 0, ISSUE at cycle 2, RUN cycles 3..D+3, rf_we_o at cycle D+4.
- Throughput: one instruction per D+5 cycles; no overlap.

Hazards:
- rd may equal rs1/rs2. The sources are captured in READ, before the write.
- instr_ready_o=0 outside IDLE, so no new instruction is accepted mid-operation.

Decomposition:
- config_pkg already holds D, fixed_point_t, vector_t and operation_t.
- Add to config_pkg: NUM_VREGS default constant and the seq_state_e enum.
- Single module, no sub-module. The FU and register file are external and are instantiated in the bench and the parent.

Test Plan:
1. D=4, v1=[1,2,3,4], v2=[10,20,30,40], ADD rs1=1 rs2=2 rd=3 -> rf_we_o at cycle D+4=8 with wdata [11,22,33,44] to addr 3; done_o is a single pulse.
2. SUB with rd=rs1=1, v1=[5,5,5,5], v2=[1,2,3,4] -> writes [4,3,2,1] to reg 1; the sources were captured before the write.
3. FU ready held low for 3 extra cycles in ISSUE -> fu_valid_o stays high and operands stay stable; rf_we_o is delayed by exactly 3 cycles.
4. Illegal operation_t encoding -> no fu_valid_o; done_o=1, err_o=1, rf_we_o=0 at cycle 2.
5. rst_ni asserted in the 2nd RUN cycle -> outputs return to their reset values immediately (async); no rf write; the next ADD completes correctly.
6. Back-to-back instructions with instr_valid_i held high -> the second is accepted only the cycle after WRITEBACK; both results are correct.
